block_buffer_fetcher: RTL

//  Parametrised multi-channel block fetcher for the stereo matching path. Per accepted request it

---
 rtl/block_fetch_pkg.sv | 34 +++
 rtl/fetch_tag_pipe.sv | 44 ++++
 rtl/block_buffer_fetcher.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/block_fetch_pkg.sv
// Shared types and geometry defaults for the stereo block fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state type, default frame/tile geometry and tile index
// helpers that map a linear element index k (column fastest) to row/column.
package block_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_BLOCK_H    = 6;
    localparam int DEF_BLOCK_W    = 2;
    localparam int DEF_WORD_W     = 48;
    localparam int DEF_ROW_WORDS  = 40;
    localparam int DEF_NUM_ROWS   = 320;
    localparam int DEF_RD_LATENCY = 2;

    // Tile row of element k; elements are numbered row-major, column fastest.
    function automatic int tile_row(input int k, input int blk_w);
        return k / blk_w;
    endfunction

    // Tile column of element k.
    function automatic int tile_col(input int k, input int blk_w);
        return k % blk_w;
    endfunction

endpackage

// File: rtl/fetch_tag_pipe.sv
// Valid + tag delay line that tracks reads in flight against a fixed-latency BRAM.
// Latency: DEPTH cycles from src_vld/src_dat to dst_vld/dst_dat.
// Backpressure: none; the pipe always advances, any_vld reports reads still in flight.
//
// Ports:
//   clk_in, rst_in    clock, asynchronous active-low reset
//   src_vld, src_dat  tag entering alongside a BRAM address
//   dst_vld, dst_dat  tag emerging alongside the matching BRAM data
//   any_vld           at least one stage holds a valid tag
module fetch_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             src_vld,
    input  logic [TAG_W-1:0] src_dat,
    output logic             dst_vld,
    output logic [TAG_W-1:0] dst_dat,
    output logic             any_vld
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][TAG_W-1:0] dat_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= src_vld;
            dat_q[0] <= src_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign dst_vld = vld_q[DEPTH-1];
    assign dst_dat = dat_q[DEPTH-1];
    assign any_vld = |vld_q;

endmodule

// File: rtl/block_buffer_fetcher.sv
// Fetches a BLOCK_H x BLOCK_W word tile per channel from line-packed frame BRAMs, channels in lockstep.
// Latency: one address per cycle; valid_out pulses N+RD_LATENCY+2 cycles after the accepting cycle.
// Backpressure: ready_out is high only in IDLE; valid_in at any other time is ignored.
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-low reset (aborts a fetch in flight)
//   valid_in, ready_out  request handshake; y_in/word_in give each channel's tile origin
//   addr_out, dout_in    per-channel BRAM read port (dout_in trails addr_out by RD_LATENCY)
//   tile_out, oob_out    per-channel tile (row-major) and out-of-frame flag of the last fetch
//   valid_out            one-cycle pulse: tile_out/oob_out are complete
module block_buffer_fetcher
    import block_fetch_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int BLOCK_H    = DEF_BLOCK_H,
    parameter  int BLOCK_W    = DEF_BLOCK_W,
    parameter  int WORD_W     = DEF_WORD_W,
    parameter  int ROW_WORDS  = DEF_ROW_WORDS,
    parameter  int NUM_ROWS   = DEF_NUM_ROWS,
    parameter  int RD_LATENCY = DEF_RD_LATENCY,
    localparam int Y_W        = $clog2(NUM_ROWS) + 1,
    localparam int X_W        = $clog2(ROW_WORDS) + 1,
    localparam int A_W        = $clog2(NUM_ROWS * ROW_WORDS)
) (
    input  logic                                                 clk_in,
    input  logic                                                 rst_in,
    input  logic                                                 valid_in,
    output logic                                                 ready_out,
    input  logic [NUM_CH-1:0][Y_W-1:0]                           y_in,
    input  logic [NUM_CH-1:0][X_W-1:0]                           word_in,
    output logic [NUM_CH-1:0][A_W-1:0]                           addr_out,
    input  logic [NUM_CH-1:0][WORD_W-1:0]                        dout_in,
    output logic [NUM_CH-1:0][BLOCK_H-1:0][BLOCK_W-1:0][WORD_W-1:0] tile_out,
    output logic [NUM_CH-1:0]                                    oob_out,
    output logic                                                 valid_out
);

    localparam int N   = BLOCK_H * BLOCK_W;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam int R_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam int C_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    // One bit wider than the address so out-of-frame sums never wrap before the compare.
    localparam int E_W = A_W + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    typedef struct packed {
        logic [K_W-1:0]    k;
        logic [NUM_CH-1:0] oob;
    } tag_t;

    fetch_state_t              state_q, state_d;
    logic [K_W-1:0]            k_q;
    logic [NUM_CH-1:0][Y_W-1:0] y_q;
    logic [NUM_CH-1:0][X_W-1:0] x_q;
    logic                      accept;
    logic                      issuing;
    logic                      pipe_busy;
    logic [R_W-1:0]            iss_row;
    logic [C_W-1:0]            iss_col;
    logic [NUM_CH-1:0]         iss_oob;
    tag_t                      iss_tag;
    logic                      cap_vld;
    tag_t                      cap_tag;
    logic [R_W-1:0]            cap_row;
    logic [C_W-1:0]            cap_col;

    assign accept  = valid_in && (state_q == IDLE);
    assign issuing = (state_q == ISSUE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_out = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) state_d = ISSUE;
            end
            ISSUE: begin
                if (k_q == K_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                // Wait until the last captured read has left the pipe.
                if (!pipe_busy) state_d = DONE;
            end
            DONE: begin
                valid_out = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request latch + element counter ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            k_q <= '0;
            y_q <= '0;
            x_q <= '0;
        end else if (accept) begin
            k_q <= '0;
            y_q <= y_in;
            x_q <= word_in;
        end else if (issuing && (k_q != K_LAST)) begin
            k_q <= k_q + 1'b1;
        end
    end

    assign iss_row = R_W'(tile_row(int'(k_q), BLOCK_W));
    assign iss_col = C_W'(tile_col(int'(k_q), BLOCK_W));

    // ---------------- per-channel address / out-of-frame ----------------
    // addr_out is a function of registered state only, so element k is on the
    // port in the cycle the counter holds k.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [E_W-1:0] r_ext;
        logic [E_W-1:0] c_ext;
        logic [A_W-1:0] lin;

        assign r_ext       = E_W'(y_q[ch]) + E_W'(iss_row);
        assign c_ext       = E_W'(x_q[ch]) + E_W'(iss_col);
        assign iss_oob[ch] = (r_ext >= E_W'(NUM_ROWS)) || (c_ext >= E_W'(ROW_WORDS));
        assign lin         = A_W'(r_ext) * A_W'(ROW_WORDS) + A_W'(c_ext);
        assign addr_out[ch] = (issuing && !iss_oob[ch]) ? lin : '0;
    end

    assign iss_tag.k   = k_q;
    assign iss_tag.oob = iss_oob;

    fetch_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .TAG_W ($bits(tag_t))
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .src_vld (issuing),
        .src_dat (iss_tag),
        .dst_vld (cap_vld),
        .dst_dat (cap_tag),
        .any_vld (pipe_busy)
    );

    // ---------------- capture demux ----------------
    assign cap_row = R_W'(tile_row(int'(cap_tag.k), BLOCK_W));
    assign cap_col = C_W'(tile_col(int'(cap_tag.k), BLOCK_W));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tile_out <= '0;
            oob_out  <= '0;
        end else begin
            if (accept) begin
                oob_out <= '0;
            end else if (cap_vld) begin
                oob_out <= oob_out | cap_tag.oob;
            end
            if (cap_vld) begin
                // Out-of-frame reads went to address 0; their data is replaced by zero.
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    tile_out[ch][cap_row][cap_col] <= cap_tag.oob[ch] ? '0 : dout_in[ch];
                end
            end
        end
    end

endmodule
